i2c_slave: RTL

I2C target (responder) for the same bus the I2C master drives; it is the on-chip peer used for loopback and sensor-emulation benches.
- Samples oversampled SCL/SDA in the system clock domain and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs, then exchanges bytes with a simple byte-stream interface on the fabric side.
- Drives SDA open-drain (low-or-release only).

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_bus_sync.sv | 41 ++++
 rtl/i2c_slave.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, bus-condition codes and ACK levels for the I2C blocks
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;
  localparam logic [1:0] START_CODE = 2'b10;
  localparam logic [1:0] STOP_CODE  = 2'b01;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchroniser with SCL edge, START and STOP detection
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda, w_scl_high;
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  // synchronise both lines and keep one history sample; idle bus level is high
  always_ff @(posedge clk)
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  assign w_scl_high = w_scl & r_scl_d;
  assign scl_rise   = w_scl & ~r_scl_d;
  assign scl_fall   = ~w_scl & r_scl_d;
  assign start_det  = w_scl_high & ({r_sda_d, w_sda} == START_CODE);
  assign stop_det   = w_scl_high & ({r_sda_d, w_sda} == STOP_CODE);
  assign sda_s      = w_sda;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with 7-bit address match and byte-stream fabric side; I2C_STRETCH_EN adds read-ACK clock stretching
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR    = 7'h58,
  parameter int         HOLD_CYC    = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       addressed
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s, w_hold_done;
  state_t r_state, w_state;
  logic [3:0] r_bit, w_bit;
  logic [7:0] r_shift, w_shift, r_rx_data, w_rx_data;
  logic [HW-1:0] r_hold, w_hold;
  logic r_rw, w_rw, r_first, w_first, r_sda_oe, w_sda_oe;
  logic r_rx_valid, w_rx_valid, r_rx_first, w_rx_first, r_tx_req, w_tx_req;
  logic r_busy, w_busy, r_addressed, w_addressed;
  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );
  assign w_hold_done = (r_hold == HW'(1));
  // next-state and datapath decode; bus conditions override any data edge
  always_comb begin
    w_state     = r_state;
    w_bit       = r_bit;
    w_shift     = r_tx_req ? tx_data : r_shift;
    w_rw        = r_rw;
    w_first     = r_first;
    w_sda_oe    = r_sda_oe;
    w_rx_data   = r_rx_data;
    w_rx_valid  = 1'b0;
    w_rx_first  = 1'b0;
    w_tx_req    = 1'b0;
    w_busy      = r_busy;
    w_addressed = 1'b0;
    w_hold      = w_scl_fall ? HW'(HOLD_CYC) : (r_hold != '0) ? r_hold - HW'(1) : r_hold;
    if (w_start) begin
      w_state  = ADDR;
      w_bit    = 4'd0;
      w_sda_oe = 1'b0;
    end else if (w_stop) begin
      w_state  = IDLE;
      w_bit    = 4'd0;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
    end else begin
      case (r_state)
        ADDR: if (w_scl_rise) begin
          w_shift = {r_shift[6:0], w_sda_s};
          w_bit   = (r_bit == 4'd7) ? 4'd0 : r_bit + 4'd1;
          if (r_bit == 4'd7) begin
            w_state     = (r_shift[6:0] == SLV_ADDR) ? ADDR_ACK : WAIT_STOP;
            w_addressed = (r_shift[6:0] == SLV_ADDR);
            w_busy      = (r_shift[6:0] == SLV_ADDR);
            w_rw        = w_sda_s;
            w_first     = 1'b1;
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (w_hold_done) w_sda_oe = ~ACK;
          if (w_scl_rise) begin
            w_bit    = 4'd0;
            w_state  = r_rw ? RD_BYTE : WR_BYTE;
            w_tx_req = r_rw;
          end
        end
        WR_BYTE: begin
          if (w_hold_done) w_sda_oe = 1'b0;
          if (w_scl_rise) begin
            w_shift = {r_shift[6:0], w_sda_s};
            w_bit   = (r_bit == 4'd7) ? 4'd0 : r_bit + 4'd1;
            if (r_bit == 4'd7) begin
              w_rx_data  = {r_shift[6:0], w_sda_s};
              w_rx_valid = 1'b1;
              w_rx_first = r_first;
              w_first    = 1'b0;
              w_state    = WR_ACK;
            end
          end
        end
        RD_BYTE: if (w_hold_done) begin
          if (r_bit == 4'd8) begin
            w_sda_oe = 1'b0;
            w_state  = RD_ACK;
          end else begin
            w_sda_oe = ~r_shift[7];
            w_shift  = {r_shift[6:0], 1'b0};
            w_bit    = r_bit + 4'd1;
          end
        end
        RD_ACK: if (w_scl_rise) begin
          w_state  = (w_sda_s == NACK) ? WAIT_STOP : RD_BYTE;
          w_busy   = (w_sda_s != NACK);
          w_tx_req = (w_sda_s != NACK);
          w_bit    = 4'd0;
        end
        default: ;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk)
    if (!reset) begin
      r_state     <= IDLE;
      r_bit       <= 4'd0;
      r_shift     <= 8'd0;
      r_hold      <= '0;
      r_rw        <= 1'b0;
      r_first     <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_addressed <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      r_hold      <= w_hold;
      r_rw        <= w_rw;
      r_first     <= w_first;
      r_sda_oe    <= w_sda_oe;
      r_rx_data   <= w_rx_data;
      r_rx_valid  <= w_rx_valid;
      r_rx_first  <= w_rx_first;
      r_tx_req    <= w_tx_req;
      r_busy      <= w_busy;
      r_addressed <= w_addressed;
    end
`ifdef I2C_STRETCH_EN
  logic r_scl_oe;
  // hold SCL low from the read ACK-phase fall until the first read bit is on SDA
  always_ff @(posedge clk)
    if (!reset) r_scl_oe <= 1'b0;
    else r_scl_oe <= (r_state == RD_BYTE && r_bit == 4'd0) ? (r_scl_oe | w_scl_fall) : 1'b0;
  assign scl_oe = r_scl_oe;
`else
  assign scl_oe = 1'b0;
`endif
  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_first  = r_rx_first;
  assign tx_req    = r_tx_req;
  assign busy      = r_busy;
  assign addressed = r_addressed;
endmodule
